// File: rtl/add_err_pkg.sv
// Shared widths, state encoding and error helper for the approximate-adder error monitor.
package add_err_pkg;
  localparam int W            = 8;
  localparam int CNT_W        = 32;
  localparam int ABS_W        = W + 1;
  localparam int SQ_W         = 2 * W + 2;
  localparam int SUM_ABS_W    = CNT_W + W + 1;
  localparam int SUM_SQ_W     = CNT_W + 2 * W + 2;
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // |(a+b) - o|, computed in W+2 signed bits so both error directions fit
  function automatic logic [ABS_W-1:0] abs_err(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [W:0]   o);
    logic [W+1:0] diff;
    diff = {1'b0, ({1'b0, a} + {1'b0, b})} - {1'b0, o};
    return diff[W+1] ? ABS_W'(-diff) : ABS_W'(diff);
  endfunction
endpackage

// File: rtl/add_err_datapath.sv
// Exact-sum / absolute-error stage with valid; the square feeds the accumulator stage in the top.
module add_err_datapath
  import add_err_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             fire_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [W:0]       o_i,
  output logic             s1_valid_o,
  output logic [ABS_W-1:0] s1_abs_o,
  output logic [SQ_W-1:0]  s1_sq_o
);
  logic             valid_q;
  logic [ABS_W-1:0] abs_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q <= 1'b0;
      abs_q   <= '0;
    end else begin
      valid_q <= fire_i;
      if (fire_i) abs_q <= abs_err(a_i, b_i, o_i);
    end
  end

  assign s1_valid_o = valid_q;
  assign s1_abs_o   = abs_q;
  assign s1_sq_o    = SQ_W'(abs_q) * SQ_W'(abs_q);
endmodule

// File: rtl/add8u_err_monitor.sv
// Error-statistics monitor for an 8-bit approximate adder: sequencing FSM, sample counter
// and the EP/MAE/MSE/WCE accumulators fed by add_err_datapath.
module add8u_err_monitor
  import add_err_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     n_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  input  logic [W:0]           in_o,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [SUM_ABS_W-1:0] sum_abs_err,
  output logic [SUM_SQ_W-1:0]  sum_sq_err,
  output logic [ABS_W-1:0]     wce
);
  state_e               state_q;
  logic [1:0]           drain_q;
  logic [CNT_W-1:0]     target_q, sample_cnt_q, err_cnt_q;
  logic [SUM_ABS_W-1:0] sum_abs_q;
  logic [SUM_SQ_W-1:0]  sum_sq_q;
  logic [ABS_W-1:0]     wce_q;
  logic                 busy_q, done_q;
  logic                 start_ok, fire, s1_valid;
  logic [ABS_W-1:0]     s1_abs;
  logic [SQ_W-1:0]      s1_sq;

  assign start_ok = (state_q == IDLE) && start;
  assign in_ready = (state_q == RUN) && (sample_cnt_q < target_q);
  assign fire     = in_valid && in_ready;

  add_err_datapath u_dp (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start_ok),
    .fire_i     (fire),
    .a_i        (in_a),
    .b_i        (in_b),
    .o_i        (in_o),
    .s1_valid_o (s1_valid),
    .s1_abs_o   (s1_abs),
    .s1_sq_o    (s1_sq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      target_q     <= '0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_abs_q    <= '0;
      sum_sq_q     <= '0;
      wce_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (s1_valid) begin
        if (s1_abs != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
        sum_abs_q <= sum_abs_q + SUM_ABS_W'(s1_abs);
        sum_sq_q  <= sum_sq_q + SUM_SQ_W'(s1_sq);
        if (s1_abs > wce_q) wce_q <= s1_abs;
      end
      // start clears are placed after the accumulation so they take priority
      case (state_q)
        IDLE: if (start) begin
          target_q     <= n_samples;
          sample_cnt_q <= '0;
          err_cnt_q    <= '0;
          sum_abs_q    <= '0;
          sum_sq_q     <= '0;
          wce_q        <= '0;
          if (n_samples == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: if (fire) begin
          sample_cnt_q <= sample_cnt_q + CNT_W'(1);
          if (sample_cnt_q + CNT_W'(1) == target_q) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          drain_q <= drain_q + 2'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign sum_abs_err = sum_abs_q;
  assign sum_sq_err  = sum_sq_q;
  assign wce         = wce_q;
endmodule

// File: tb/tb_add8u_err_monitor.sv
// Bench for add8u_err_monitor: constant-error vector table, random runs against an arithmetic
// model, and hand sequences for handshake, zero-length, start-while-busy and mid-run reset.
module tb_add8u_err_monitor;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, busy, done;
  logic [31:0] n_samples, sample_cnt, err_cnt;
  logic [7:0]  in_a, in_b;
  logic [8:0]  in_o, wce;
  logic [40:0] sum_abs_err;
  logic [49:0] sum_sq_err;

  add8u_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_o(in_o),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err), .wce(wce)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int a; int b; int o;
    longint e_err; longint e_abs; longint e_sq; longint e_wce;
  } vec_t;

  int          tests = 0, fails = 0;
  int          qa[$], qb[$], qo[$], vpat[$];
  int unsigned vprob = 100;
  int          poke_k = -1;
  vec_t        tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_const(input int n, input int a, input int b, input int o);
    qa.delete(); qb.delete(); qo.delete();
    for (int i = 0; i < n; i++) begin qa.push_back(a); qb.push_back(b); qo.push_back(o); end
  endtask

  task automatic load_rand(input int n, input bit exact);
    int a, b;
    qa.delete(); qb.delete(); qo.delete();
    for (int i = 0; i < n; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      qa.push_back(a); qb.push_back(b);
      if (exact || $urandom_range(0, 3) == 0) qo.push_back(a + b);
      else qo.push_back(int'($urandom_range(0, 511)));
    end
  endtask

  // Runs one start..done transaction using the queued samples; expectations come from the
  // table when have_exp is set, otherwise from plain arithmetic over the queued samples.
  task automatic do_run(input string tag, input int n, input bit have_exp,
                        input longint t_err, input longint t_abs, input longint t_sq,
                        input longint t_wce);
    longint m_err = 0, m_abs = 0, m_sq = 0, m_wce = 0;
    int idx = 0, extra = 0, k = 0, last_acc = -1, done_k = -1, budget, d;
    bit v;
    for (int i = 0; i < n; i++) begin
      d = qa[i] + qb[i] - qo[i];
      if (d < 0) d = -d;
      if (d != 0) m_err++;
      m_abs += d;
      m_sq  += longint'(d) * longint'(d);
      if (d > m_wce) m_wce = d;
    end
    if (have_exp) begin m_err = t_err; m_abs = t_abs; m_sq = t_sq; m_wce = t_wce; end

    @(negedge clk);
    n_samples = 32'(n); start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) chk({tag, " busy after start"}, longint'(busy), 1);
    budget = 20 * n + 40;
    while (done_k < 0 && k < budget) begin
      if (done === 1'b1) begin
        done_k = k;
      end else begin
        start = (k == poke_k);
        if (k == poke_k) n_samples = 32'd2;
        if (vpat.size() > 0) v = (vpat.pop_front() != 0);
        else v = ($urandom_range(1, 100) <= vprob);
        if (idx < n) begin
          in_a = 8'(qa[idx]); in_b = 8'(qb[idx]); in_o = 9'(qo[idx]);
        end else begin
          in_a = 8'd1; in_b = 8'd1; in_o = 9'd0;
        end
        in_valid = v;
        if (v && in_ready) begin
          if (idx < n) idx++; else extra++;
          last_acc = k;
        end
        @(negedge clk);
        k++;
      end
    end
    in_valid = 1'b0; start = 1'b0;
    if (done_k < 0) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, budget);
      return;
    end
    chk({tag, " accepts"}, idx + extra, n);
    chk({tag, " done latency"}, done_k, (n == 0) ? 0 : last_acc + 3);
    chk({tag, " sample_cnt"}, longint'(sample_cnt), n);
    chk({tag, " err_cnt"}, longint'(err_cnt), m_err);
    chk({tag, " sum_abs_err"}, longint'(sum_abs_err), m_abs);
    chk({tag, " sum_sq_err"}, longint'(sum_sq_err), m_sq);
    chk({tag, " wce"}, longint'(wce), m_wce);
    chk({tag, " busy at done"}, longint'(busy), 0);
    @(negedge clk);
    chk({tag, " done one cycle"}, longint'(done), 0);
    chk({tag, " hold sum_abs"}, longint'(sum_abs_err), m_abs);
    chk({tag, " idle in_ready"}, longint'(in_ready), 0);
  endtask

  initial begin
    int acc, guard;
    tbl[0] = '{4,   3,   1,   0,  4,   16,     64,   4};
    tbl[1] = '{5,  10,  20,  30,  0,    0,      0,   0};
    tbl[2] = '{3, 100, 100, 180,  3,   60,   1200,  20};
    tbl[3] = '{2,   0,   0, 511,  2, 1022, 522242, 511};
    tbl[4] = '{1, 255, 255,   0,  1,  510, 260100, 510};
    tbl[5] = '{6, 200, 100, 255,  6,  270,  12150,  45};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_samples = '0;
    in_a = '0; in_b = '0; in_o = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset in_ready", longint'(in_ready), 0);
    chk("reset sample_cnt", longint'(sample_cnt), 0);
    chk("reset sum_sq_err", longint'(sum_sq_err), 0);
    chk("reset wce", longint'(wce), 0);

    foreach (tbl[i]) begin
      load_const(tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].o);
      vprob = 100;
      do_run($sformatf("vec%0d", i), tbl[i].n, 1'b1,
             tbl[i].e_err, tbl[i].e_abs, tbl[i].e_sq, tbl[i].e_wce);
    end

    qa = '{255, 0}; qb = '{255, 0}; qo = '{0, 511};
    do_run("extreme", 2, 1'b1, 2, 1021, 521221, 511);

    load_rand(256, 1'b1);
    vprob = 100;
    do_run("exact adder", 256, 1'b1, 0, 0, 0, 0);

    load_rand(200, 1'b0);
    vprob = 70;
    do_run("random", 200, 1'b0, 0, 0, 0, 0);

    load_const(3, 50, 60, 100);
    vpat = '{1, 0, 1, 1, 1};
    vprob = 100;
    do_run("handshake", 3, 1'b0, 0, 0, 0, 0);

    qa.delete(); qb.delete(); qo.delete();
    do_run("zero", 0, 1'b1, 0, 0, 0, 0);

    load_rand(20, 1'b0);
    vprob = 60; poke_k = 4;
    do_run("start in run", 20, 1'b0, 0, 0, 0, 0);
    poke_k = -1;

    // mid-run reset with pipeline still full of erroneous samples
    load_const(100, 7, 9, 0);
    @(negedge clk);
    n_samples = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0; guard = 0;
    while (acc < 10 && guard < 50) begin
      in_valid = 1'b1; in_a = 8'd7; in_b = 8'd9; in_o = 9'd0;
      if (in_ready) acc++;
      @(negedge clk);
      guard++;
    end
    chk("pre-reset sample_cnt", longint'(sample_cnt), 10);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-reset busy", longint'(busy), 0);
    chk("mid-reset in_ready", longint'(in_ready), 0);
    chk("mid-reset sample_cnt", longint'(sample_cnt), 0);
    chk("mid-reset err_cnt", longint'(err_cnt), 0);
    chk("mid-reset sum_abs_err", longint'(sum_abs_err), 0);
    chk("mid-reset wce", longint'(wce), 0);
    @(negedge clk);
    chk("post-reset flush sum_sq", longint'(sum_sq_err), 0);
    chk("post-reset flush err_cnt", longint'(err_cnt), 0);

    load_rand(30, 1'b0);
    vprob = 80;
    do_run("after reset", 30, 1'b0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add8u_err_monitor.md
# add8u_err_monitor

Streaming error-characterisation stage that sits directly downstream of an 8-bit approximate unsigned adder. Each cycle it takes the operand pair driven into the adder together with the adder's 9-bit result, computes the exact sum internally and accumulates error statistics over a programmed number of samples. The statistics are error count (for EP), sum of absolute error (MAE), sum of squared error (MSE) and worst-case error (WCE). It is the on-chip counterpart of the offline MAE/WCE/MSE/EP figures attached to every adder in the library.

## Interface
- W, 8, operand width; adder result is W+1 bits
- CNT_W, 32, sample-counter width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches n_samples and clears statistics
- n_samples  in  CNT_W  number of samples to accumulate
- in_valid  in  1  sample present on in_a/in_b/in_o
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_a, in_b  in  W  operands fed to the approximate adder
- in_o  in  W+1  approximate adder result
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when statistics are final
- sample_cnt  out  CNT_W  samples accepted since start
- err_cnt  out  CNT_W  samples with in_o != in_a+in_b
- sum_abs_err  out  CNT_W+W+1  Σ|exact−approx|
- sum_sq_err  out  CNT_W+2W+2  Σ(exact−approx)²
- wce  out  W+1  max |exact−approx|

## Operation
- FSM states and transitions:
  - IDLE: start → RUN; if n_samples==0, start → DONE instead.
  - RUN: leaves for DRAIN when sample_cnt reaches the target.
  - DRAIN: 2 cycles, flushes the pipeline.
  - DONE: 1 cycle, asserts done, then returns to IDLE.
- Outputs in IDLE hold the last results until the next start.
- in_ready = (state==RUN) && (sample_cnt < target). Samples presented outside RUN are ignored.
- start while busy is ignored.
- Arithmetic:
  - exact = in_a + in_b, W+1 bits.
  - diff = exact − in_o, signed W+2 bits.
  - abs = |diff|, W+1 bits, maximum 2^(W+1)−1.
  - sq = abs², 2W+2 bits.
- Accumulator widths are sized so that no overflow is possible for ≤2^CNT_W−1 samples. No saturation logic is needed.
- err_cnt increments when abs != 0. wce = max(wce, abs).
- Reset or start clears sample_cnt, err_cnt, sum_abs_err, sum_sq_err and wce to 0, and resets the pipeline valids.

## Timing
- All outputs reset to 0; the FSM resets to IDLE.
- Pipeline stage 1 registers the accepted sample's abs and a valid bit.
- Pipeline stage 2 registers sq and updates all accumulators.
- Latency from acceptance to visible accumulator update is 2 cycles.
- sample_cnt updates on the acceptance edge itself.
- Throughput is one sample per cycle, with no bubbles while in_valid is held high.
- done asserts exactly 3 cycles after the last accepted sample: 2 DRAIN cycles plus the DONE cycle. The statistics are final in that cycle.
- Reset asserted mid-run takes effect on the next edge: state returns to IDLE and all counters clear. In-flight samples are discarded.
- A start accepted in IDLE in the same cycle as an in_valid sample does not accept that sample, because in_ready is low in IDLE.

## Structure
- Shared package add_err_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE)
  - localparam width helpers: ABS_W = W+1, SQ_W = 2W+2, SUM_ABS_W = CNT_W+W+1, SUM_SQ_W = CNT_W+2W+2
  - DRAIN_CYCLES = 2
- One sub-module, add_err_datapath, contains the two-stage exact-sum/abs/square pipeline with valid propagation.
- The top level holds the FSM, counters and accumulators.

## Test plan
- **Exact adder.** n_samples=256; in_o=in_a+in_b for random operands. Expect done after 256 samples; err_cnt=0, sum_abs_err=0, sum_sq_err=0, wce=0, sample_cnt=256.
- **Constant error.** n_samples=4; a=3, b=1, in_o=0 each sample. Expect err_cnt=4, sum_abs_err=16, sum_sq_err=64, wce=4.
- **Signed/extreme error.** First sample a=255, b=255, in_o=0 (abs=510). Second sample a=0, b=0, in_o=511 (abs=511). Expect wce=511, sum_abs_err=1021, sum_sq_err=521221, err_cnt=2.
- **Handshake.** n_samples=3 with in_valid toggling 1,0,1,1,1. Expect exactly 3 acceptances; in_ready drops after the third; the fifth sample is not counted; done is 3 cycles after the last acceptance.
- **Zero samples and re-start.** start with n_samples=0 → done on the next cycle with all statistics 0. start during RUN has no effect.
- **Reset mid-run.** After 10 of 100 samples, assert rst for 1 cycle. Expect busy=0 and all outputs 0. A subsequent start/run completes normally.
